// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: machine word plus the recovery sequencer state and cause encodings.
package rv32i_types_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } flush_state_t;

  typedef enum logic [1:0] {
    NONE,
    EXC,
    MISP,
    IFENCE
  } flush_cause_t;

  // ifence must also wait for the ROB to retire so the icache sees all older stores
  function automatic logic drain_needed(flush_cause_t cause, logic mem_busy, logic rob_empty);
    return mem_busy | ((cause == IFENCE) & ~rob_empty);
  endfunction

endpackage

// File: rtl/flush_perf_cnt.sv
// Three saturating performance counters for the recovery sequencer (used with FLUSH_PERF_CNT_EN).
module flush_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc_exc,
  input  logic             inc_misp,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] perf_exc,
  output logic [CNT_W-1:0] perf_misp,
  output logic [CNT_W-1:0] perf_stall
);

  logic [CNT_W-1:0] exc_q, exc_d;
  logic [CNT_W-1:0] misp_q, misp_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Increment unless already at all-ones
  always_comb begin
    exc_d   = exc_q;
    misp_d  = misp_q;
    stall_d = stall_q;
    if (inc_exc && (exc_q != '1))     exc_d   = exc_q + CNT_W'(1);
    if (inc_misp && (misp_q != '1))   misp_d  = misp_q + CNT_W'(1);
    if (inc_stall && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      exc_q   <= '0;
      misp_q  <= '0;
      stall_q <= '0;
    end else begin
      exc_q   <= exc_d;
      misp_q  <= misp_d;
      stall_q <= stall_d;
    end
  end

  assign perf_exc   = exc_q;
  assign perf_misp  = misp_q;
  assign perf_stall = stall_q;

endmodule

// File: rtl/ooo_flush_ctrl.sv
// Pipeline recovery sequencer: drain memory, flush stages, redirect fetch on exception/mispredict/ifence.
// Define FLUSH_PERF_CNT_EN to build the saturating perf counters; otherwise they read as zero.
module ooo_flush_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             exc_req,
  input  logic [31:0]      priv_pc,
  input  logic             mispredict,
  input  logic [31:0]      brj_addr,
  input  logic             ifence,
  input  logic [31:0]      ifence_pc,
  input  logic             d_mem_busy,
  input  logic             rob_empty,
  output logic             fetch_decode_flush,
  output logic             decode_execute_flush,
  output logic             execute_commit_flush,
  output logic             loadstore_flush,
  output logic             ifence_flush,
  output logic             stall_fetch_decode,
  output logic             npc_sel,
  output logic             insert_priv_pc,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] perf_exc,
  output logic [CNT_W-1:0] perf_misp,
  output logic [CNT_W-1:0] perf_stall
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

  flush_state_t  state_q, state_d;
  flush_cause_t  cause_q, cause_d;
  word_t         target_q, target_d;
  logic [CW-1:0] count_q, count_d;
  logic          flush_q, flush_d;
  logic          ifl_q, ifl_d;
  logic          stall_q, stall_d;
  logic          npc_q, npc_d;
  logic          priv_q, priv_d;
  logic          busy_q, busy_d;
  word_t         redirect_pc_q, redirect_pc_d;

  // Next-state logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    target_d = target_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          cause_d  = EXC;
          target_d = priv_pc;
        end else if (mispredict) begin
          cause_d  = MISP;
          target_d = brj_addr;
        end else if (ifence) begin
          cause_d  = IFENCE;
          target_d = ifence_pc;
        end
        if (exc_req || mispredict || ifence) begin
          state_d = drain_needed(cause_d, d_mem_busy, rob_empty) ? DRAIN : FLUSH;
          count_d = FLUSH_LAST;
        end
      end
      DRAIN: begin
        if (!drain_needed(cause_q, d_mem_busy, rob_empty)) begin
          state_d = FLUSH;
          count_d = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (count_q == '0) state_d = REDIRECT;
        else               count_d = count_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A late exception takes over an in-progress younger recovery
    if (((state_q == DRAIN) || (state_q == FLUSH)) && exc_req && (cause_q != EXC)) begin
      cause_d  = EXC;
      target_d = priv_pc;
      state_d  = d_mem_busy ? DRAIN : FLUSH;
      count_d  = FLUSH_LAST;
    end

    flush_d       = (state_d == FLUSH);
    ifl_d         = (state_d == FLUSH) && (cause_d == IFENCE);
    stall_d       = (state_d == DRAIN) || (state_d == FLUSH);
    npc_d         = (state_d == REDIRECT);
    priv_d        = (state_d == REDIRECT) && (cause_d == EXC);
    busy_d        = (state_d != IDLE);
    redirect_pc_d = npc_d ? target_d : redirect_pc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cause_q       <= NONE;
      target_q      <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      ifl_q         <= 1'b0;
      stall_q       <= 1'b0;
      npc_q         <= 1'b0;
      priv_q        <= 1'b0;
      busy_q        <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      target_q      <= target_d;
      count_q       <= count_d;
      flush_q       <= flush_d;
      ifl_q         <= ifl_d;
      stall_q       <= stall_d;
      npc_q         <= npc_d;
      priv_q        <= priv_d;
      busy_q        <= busy_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign fetch_decode_flush   = flush_q;
  assign decode_execute_flush = flush_q;
  assign execute_commit_flush = flush_q;
  assign loadstore_flush      = flush_q;
  assign ifence_flush         = ifl_q;
  assign stall_fetch_decode   = stall_q;
  assign npc_sel              = npc_q;
  assign insert_priv_pc       = priv_q;
  assign redirect_pc          = redirect_pc_q;
  assign busy                 = busy_q;

`ifdef FLUSH_PERF_CNT_EN
  logic inc_exc, inc_misp;

  // REDIRECT always lasts one cycle, so entering it is simply state_d == REDIRECT
  assign inc_exc  = (state_d == REDIRECT) && (cause_d == EXC);
  assign inc_misp = (state_d == REDIRECT) && (cause_d == MISP);

  flush_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .CLK       (CLK),
    .RST       (RST),
    .inc_exc   (inc_exc),
    .inc_misp  (inc_misp),
    .inc_stall (busy_q),
    .perf_exc  (perf_exc),
    .perf_misp (perf_misp),
    .perf_stall(perf_stall)
  );
`else
  assign perf_exc   = '0;
  assign perf_misp  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ooo_flush_ctrl.sv
// Scoreboard bench for ooo_flush_ctrl: stimulus queues expected redirects, a monitor checks each one.
module tb_ooo_flush_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             exc_req, mispredict, ifence, d_mem_busy, rob_empty;
  logic [31:0]      priv_pc, brj_addr, ifence_pc;
  logic             fetch_decode_flush, decode_execute_flush, execute_commit_flush, loadstore_flush;
  logic             ifence_flush, stall_fetch_decode, npc_sel, insert_priv_pc, busy;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] perf_exc, perf_misp, perf_stall;

  typedef struct {
    logic [31:0] pc;
    logic        priv;
    int          nflush;
    int          nifl;
    int          ndrain;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   nf = 0, ni = 0, nd = 0;

  ooo_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .exc_req             (exc_req),
    .priv_pc             (priv_pc),
    .mispredict          (mispredict),
    .brj_addr            (brj_addr),
    .ifence              (ifence),
    .ifence_pc           (ifence_pc),
    .d_mem_busy          (d_mem_busy),
    .rob_empty           (rob_empty),
    .fetch_decode_flush  (fetch_decode_flush),
    .decode_execute_flush(decode_execute_flush),
    .execute_commit_flush(execute_commit_flush),
    .loadstore_flush     (loadstore_flush),
    .ifence_flush        (ifence_flush),
    .stall_fetch_decode  (stall_fetch_decode),
    .npc_sel             (npc_sel),
    .insert_priv_pc      (insert_priv_pc),
    .redirect_pc         (redirect_pc),
    .busy                (busy),
    .perf_exc            (perf_exc),
    .perf_misp           (perf_misp),
    .perf_stall          (perf_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic priv, input int nfl, input int nif, input int ndr);
    exp_t e;
    e.pc = pc; e.priv = priv; e.nflush = nfl; e.nifl = nif; e.ndrain = ndr;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulate flush/drain cycles, then score them against the next expected redirect
  always @(negedge CLK) begin
    if (RST) begin
      nf = 0; ni = 0; nd = 0;
    end else begin
      if (fetch_decode_flush | decode_execute_flush | execute_commit_flush | loadstore_flush)
        chk("flush_group_equal",
            {28'd0, fetch_decode_flush, decode_execute_flush, execute_commit_flush, loadstore_flush},
            32'hF);
      if (fetch_decode_flush) nf++;
      if (ifence_flush) ni++;
      if (stall_fetch_decode && !fetch_decode_flush) nd++;
      if (npc_sel) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("redirect_pc", redirect_pc, e.pc);
          chk("insert_priv_pc", 32'(insert_priv_pc), 32'(e.priv));
          chk("flush_cycles", 32'(nf), 32'(e.nflush));
          chk("ifence_flush_cycles", 32'(ni), 32'(e.nifl));
          chk("drain_cycles", 32'(nd), 32'(e.ndrain));
          chk("stall_in_redirect", 32'(stall_fetch_decode), 32'd0);
        end
        nf = 0; ni = 0; nd = 0;
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] exp_pe, exp_pm, exp_ps;
    RST = 1'b1; exc_req = 1'b0; mispredict = 1'b0; ifence = 1'b0;
    d_mem_busy = 1'b0; rob_empty = 1'b1;
    priv_pc = '0; brj_addr = '0; ifence_pc = '0;
    tick(3);
    chk("reset_outputs",
        {22'd0, fetch_decode_flush, decode_execute_flush, execute_commit_flush, loadstore_flush,
         ifence_flush, stall_fetch_decode, npc_sel, insert_priv_pc, busy, 1'b0}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_perf_stall", perf_stall, '0);
    RST = 1'b0;
    tick(2);

    // Mispredict, no drain: flush t+1,t+2, redirect t+3
    mispredict = 1'b1; brj_addr = 32'h200; push(32'h200, 1'b0, 2, 0, 0);
    tick(); mispredict = 1'b0;
    chk("misp_flush_t1", 32'(fetch_decode_flush), 32'd1);
    tick();
    chk("misp_flush_t2", 32'(fetch_decode_flush), 32'd1);
    tick();
    chk("misp_npc_t3", 32'(npc_sel), 32'd1);
    tick();
    chk("npc_drop_t4", 32'(npc_sel), 32'd0);
    chk("redirect_hold", redirect_pc, 32'h200);
    chk("idle_busy", 32'(busy), 32'd0);
    tick(2);

    // Exception with memory busy 4 cycles; a mispredict during drain is ignored
    exc_req = 1'b1; priv_pc = 32'h100; d_mem_busy = 1'b1; push(32'h100, 1'b1, 2, 0, 4);
    tick(); exc_req = 1'b0; mispredict = 1'b1; brj_addr = 32'hDEAD;
    chk("drain_stall", {30'd0, stall_fetch_decode, fetch_decode_flush}, 32'h2);
    tick(); mispredict = 1'b0;
    tick(2); d_mem_busy = 1'b0;
    tick(8);

    // ifence waits for ROB to empty
    ifence = 1'b1; ifence_pc = 32'h400; rob_empty = 1'b0; push(32'h400, 1'b0, 2, 2, 3);
    tick(); ifence = 1'b0;
    tick(2); rob_empty = 1'b1;
    tick(8);

    // Exception preempts mispredict in its first FLUSH cycle
    mispredict = 1'b1; brj_addr = 32'h300; push(32'h80, 1'b1, 3, 0, 0);
    tick(); mispredict = 1'b0; exc_req = 1'b1; priv_pc = 32'h80;
    tick(); exc_req = 1'b0;
    tick(8);

    // Simultaneous exception and mispredict: exception only
    exc_req = 1'b1; priv_pc = 32'h140; mispredict = 1'b1; brj_addr = 32'h240;
    push(32'h140, 1'b1, 2, 0, 0);
    tick(); exc_req = 1'b0; mispredict = 1'b0;
    tick(6);

    // Reset in the middle of FLUSH
    mispredict = 1'b1; brj_addr = 32'h500;
    tick(); mispredict = 1'b0; RST = 1'b1;
    chk("pre_reset_flush", 32'(fetch_decode_flush), 32'd1);
    tick(); RST = 1'b0;
    chk("rst_mid_outputs",
        {23'd0, fetch_decode_flush, loadstore_flush, ifence_flush, stall_fetch_decode,
         npc_sel, insert_priv_pc, busy, 2'd0}, 32'd0);
    tick(3);

    // Exception held from REDIRECT into IDLE is taken back-to-back
    mispredict = 1'b1; brj_addr = 32'h600;
    push(32'h600, 1'b0, 2, 0, 0); push(32'h700, 1'b1, 2, 0, 0);
    tick(); mispredict = 1'b0;
    tick(2); exc_req = 1'b1; priv_pc = 32'h700;
    tick(2); exc_req = 1'b0;
    tick(6);

    // Exception raised only during REDIRECT is lost
    mispredict = 1'b1; brj_addr = 32'h680; push(32'h680, 1'b0, 2, 0, 0);
    tick(); mispredict = 1'b0;
    tick(2); exc_req = 1'b1; priv_pc = 32'h780;
    tick(); exc_req = 1'b0;
    tick(6);

    // Counter scenario: 1 exception + 2 mispredicts, no drain
    RST = 1'b1; tick(); RST = 1'b0; tick();
    exc_req = 1'b1; priv_pc = 32'h10; push(32'h10, 1'b1, 2, 0, 0);
    tick(); exc_req = 1'b0; tick(4);
    mispredict = 1'b1; brj_addr = 32'h20; push(32'h20, 1'b0, 2, 0, 0);
    tick(); mispredict = 1'b0; tick(4);
    mispredict = 1'b1; brj_addr = 32'h30; push(32'h30, 1'b0, 2, 0, 0);
    tick(); mispredict = 1'b0; tick(4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("pending_redirects", 32'(exp_q.size()), 32'd0);

`ifdef FLUSH_PERF_CNT_EN
    exp_pe = CNT_W'(1); exp_pm = CNT_W'(2); exp_ps = CNT_W'(9);
`else
    exp_pe = '0; exp_pm = '0; exp_ps = '0;
`endif
    chk("perf_exc", perf_exc, exp_pe);
    chk("perf_misp", perf_misp, exp_pm);
    chk("perf_stall", perf_stall, exp_ps);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
